regfile_wb_arbiter: RTL

Write-back controller for the 32×32 register file (two read ports, one write port, register 0 hard-wired to zero). It shares the single write port among three write-back requesters (ALU, load unit, multi-cycle mul/div) using round-robin arbitration. It also keeps a pending-write scoreboard, so decode can stall on read-after-write and write-after-write hazards. It sits between the execute-stage units and the register file's `wn`/`d`/`we` inputs.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: write-back requester indices, register-file geometry,
// and a small width helper used by the write-back arbiter.
package cpu_pkg;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    localparam int unsigned WB_ALU = 0;
    localparam int unsigned WB_LD  = 1;
    localparam int unsigned WB_MD  = 2;

    localparam logic [AW-1:0] REG_ZERO = '0;

    // Index width for an n-entry selector; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after ptr,
// and moves ptr just past the winner whenever a transfer happens.
module rr_arbiter #(
    parameter int unsigned NREQ = cpu_pkg::NREQ,
    localparam int unsigned IW  = cpu_pkg::idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [NREQ-1:0] valid,
    input  logic            xfer,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   gidx
);

    logic [IW-1:0] ptr;
    logic          found;
    int unsigned   pos;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        pos   = 0;
        if (!clr) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                pos = 32'(ptr) + k;
                if (pos >= NREQ) pos = pos - NREQ;
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (!found && (j == pos) && valid[j]) begin
                        grant[j] = 1'b1;
                        gidx     = IW'(j);
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the register file: round-robin sharing of the
// single write port plus a pending-write scoreboard for decode hazards.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = cpu_pkg::NREQ,
    parameter int unsigned AW   = cpu_pkg::AW,
    parameter int unsigned DW   = cpu_pkg::DW
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_wn,
    input  logic [NREQ*DW-1:0] req_d,
    output logic [NREQ-1:0]    req_ready,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_wn,
    output logic               iss_ready,
    input  logic [AW-1:0]      rna,
    input  logic [AW-1:0]      rnb,
    output logic               hazard_a,
    output logic               hazard_b,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wn,
    output logic [DW-1:0]      rf_d
);
    import cpu_pkg::*;

    localparam int unsigned NR = 1 << AW;
    localparam int unsigned IW = idx_w(NREQ);

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            xfer;
    logic [AW-1:0]   sel_wn;
    logic [DW-1:0]   sel_d;
    logic [NR-1:0]   busy;
    logic [NR-1:0]   busy_n;
    logic            iss_take;

    assign xfer      = |(req_valid & grant);
    assign req_ready = grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .clr   (clr),
        .valid (req_valid),
        .xfer  (xfer),
        .grant (grant),
        .gidx  (gidx)
    );

    always_comb begin
        sel_wn = '0;
        sel_d  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (gidx == IW'(j)) begin
                sel_wn = req_wn[j*AW +: AW];
                sel_d  = req_d[j*DW +: DW];
            end
        end
    end

    // A destination-0 transfer still goes through the port but never enables the write.
    always_ff @(posedge clk) begin
        if (clr) begin
            rf_we <= 1'b0;
            rf_wn <= '0;
            rf_d  <= '0;
        end else if (xfer) begin
            rf_we <= (sel_wn != REG_ZERO);
            rf_wn <= sel_wn;
            rf_d  <= sel_d;
        end else begin
            rf_we <= 1'b0;
        end
    end

    assign iss_ready = !clr && !((iss_wn != REG_ZERO) && busy[iss_wn]);
    assign iss_take  = iss_valid && iss_ready && (iss_wn != REG_ZERO);
    assign hazard_a  = (rna != REG_ZERO) && busy[rna];
    assign hazard_b  = (rnb != REG_ZERO) && busy[rnb];

    // Clear first so a same-cycle issue to the committing register keeps it busy.
    always_comb begin
        busy_n = busy;
        if (rf_we) busy_n[rf_wn] = 1'b0;
        if (iss_take) busy_n[iss_wn] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            busy <= '0;
        end else begin
            busy <= busy_n;
        end
    end

endmodule
